// File: rtl/catc_pace_monitor.sv
// Pace monitor for the CATC clock-enable path: tracks RefEn vs CoreEn lag and drives FastCatchup.
// Optional statistics (LagMax, BehindCycles, BehindMax) are built only when CATC_MONITOR_STATS_EN is defined.
module catc_pace_monitor #(
  parameter int LAG_WIDTH    = 16,
  parameter int TIME_WIDTH   = 24,
  parameter int CATCHUP_ON   = 4,
  parameter int CATCHUP_OFF  = 1,
  parameter int DESYNC_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic                  RefEn,
  input  logic                  CoreEn,
  output logic                  FastCatchup,
  output logic [LAG_WIDTH-1:0]  Lag,
  output logic [LAG_WIDTH-1:0]  LagMax,
  output logic [TIME_WIDTH-1:0] BehindCycles,
  output logic [TIME_WIDTH-1:0] BehindMax,
  output logic                  Desync,
  output logic                  Ahead
);

  typedef enum logic [1:0] {
    TRACK   = 2'd0,
    CATCHUP = 2'd1,
    DESYNC  = 2'd2
  } state_t;

  localparam logic [LAG_WIDTH-1:0] LAG_ONES    = '1;
  localparam logic [LAG_WIDTH-1:0] LAG_ON      = LAG_WIDTH'(CATCHUP_ON);
  localparam logic [LAG_WIDTH-1:0] LAG_OFF     = LAG_WIDTH'(CATCHUP_OFF);
  localparam logic [LAG_WIDTH-1:0] LAG_DESYNC  = LAG_WIDTH'(DESYNC_LIMIT);

  state_t state, state_next;
  logic   in_desync;
  logic   lag_zero;
  logic   underflow;

  assign lag_zero  = (Lag == '0);
  assign underflow = CoreEn && !RefEn && lag_zero;

  // Lag counter: saturates at all-ones and never goes below zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset) begin
      Lag <= '0;
    end else if (RefEn && !CoreEn) begin
      if (Lag != LAG_ONES) Lag <= Lag + 1'b1;
    end else if (CoreEn && !RefEn) begin
      if (!lag_zero) Lag <= Lag - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) state <= TRACK;
    else       state <= state_next;
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    unique case (state)
      TRACK: begin
        if (Lag >= LAG_DESYNC)  state_next = DESYNC;
        else if (Lag >= LAG_ON) state_next = CATCHUP;
      end
      CATCHUP: begin
        if (Lag >= LAG_DESYNC)   state_next = DESYNC;
        else if (Lag <= LAG_OFF) state_next = TRACK;
      end
      DESYNC: begin
        if (lag_zero) state_next = TRACK;
      end
      default: state_next = TRACK;
    endcase
  end

  always_comb begin
    FastCatchup = 1'b0;
    in_desync   = 1'b0;
    unique case (state)
      TRACK:   FastCatchup = 1'b0;
      CATCHUP: FastCatchup = 1'b1;
      DESYNC: begin
        FastCatchup = 1'b1;
        in_desync   = 1'b1;
      end
      default: FastCatchup = 1'b0;
    endcase
  end

  // Sticky flags: set alongside the state entering DESYNC; Clear wins and the flag re-sets while DESYNC persists.
  always_ff @(posedge clk) begin
    if (Reset || Clear) begin
      Desync <= 1'b0;
      Ahead  <= 1'b0;
    end else begin
      if (state_next == DESYNC) Desync <= 1'b1;
      if (underflow)            Ahead  <= 1'b1;
    end
  end

`ifdef CATC_MONITOR_STATS_EN
  localparam logic [TIME_WIDTH-1:0] TIME_ONES = '1;

  always_ff @(posedge clk) begin
    if (Reset) begin
      BehindCycles <= '0;
    end else if (lag_zero) begin
      BehindCycles <= '0;
    end else if (BehindCycles != TIME_ONES) begin
      BehindCycles <= BehindCycles + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset || Clear) begin
      LagMax    <= '0;
      BehindMax <= '0;
    end else begin
      if (Lag > LagMax)             LagMax    <= Lag;
      if (BehindCycles > BehindMax) BehindMax <= BehindCycles;
    end
  end
`else
  assign BehindCycles = '0;
  assign LagMax       = '0;
  assign BehindMax    = '0;
`endif

endmodule
